// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path.
// The fetch unit and ALU control decode the same state, PC_SEL, ALUSrcB and ALUOp values.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch     = 4'd0,
        StDecode    = 4'd1,
        StMemAddr   = 4'd2,
        StMemRead   = 4'd3,
        StMemWb     = 4'd4,
        StMemWrite  = 4'd5,
        StRExec     = 4'd6,
        StRWb       = 4'd7,
        StIExec     = 4'd8,
        StIWb       = 4'd9,
        StBranch    = 4'd10,
        StJump      = 4'd11,
        StJr        = 4'd12,
        StException = 4'd13
    } state_e;

    localparam logic [5:0] OpRType = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnJr  = 6'h08;
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;

    localparam logic [2:0] PcSelAluOut    = 3'd0;
    localparam logic [2:0] PcSelAluRegOut = 3'd1;
    localparam logic [2:0] PcSelJump      = 3'd2;
    localparam logic [2:0] PcSelReg1      = 3'd3;
    localparam logic [2:0] PcSelVector    = 3'd4;

    localparam logic [1:0] AluSrcBReg2     = 2'd0;
    localparam logic [1:0] AluSrcBFour     = 2'd1;
    localparam logic [1:0] AluSrcBImm      = 2'd2;
    localparam logic [1:0] AluSrcBImmShift = 2'd3;

    localparam logic [1:0] AluOpAdd   = 2'd0;
    localparam logic [1:0] AluOpSub   = 2'd1;
    localparam logic [1:0] AluOpFunct = 2'd2;
    localparam logic [1:0] AluOpImm   = 2'd3;

    localparam logic CauseUndef    = 1'b0;
    localparam logic CauseOverflow = 1'b1;

    typedef struct packed {
        logic       pc_load;
        logic       iord;
        logic       ir_en;
        logic       epc_en;
        logic [2:0] pc_sel;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    // States whose final cycle completes an instruction.
    function automatic logic is_retire_state(input state_e s);
        logic r;
        case (s)
            StMemWb, StMemWrite, StRWb, StIWb, StBranch, StJump, StJr: r = 1'b1;
            default:                                                   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/multicycle_control_unit.sv
// Main Moore control FSM of the multi-cycle MIPS core with a retired-instruction counter.
// Only PC_LOAD in the branch state looks at the live ALU Zero flag.
module multicycle_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [5:0]           Opcode,
    input  logic [5:0]           Funct,
    input  logic                 Zero,
    input  logic                 Overflow,
    output logic                 PC_LOAD,
    output logic                 IorD,
    output logic                 IR_EN,
    output logic                 EPC_EN,
    output logic [2:0]           PC_SEL,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic                 RegDst,
    output logic                 MemtoReg,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ALUOp,
    output logic                 Cause,
    output logic [CNT_WIDTH-1:0] INSTR_RETIRED
);

    state_e               r_state;
    state_e               w_state_next;
    logic                 r_cause;
    logic                 w_cause_next;
    logic [CNT_WIDTH-1:0] r_instr_retired;
    logic                 w_retire;
    ctrl_t                w_ctrl;

    assign w_retire = is_retire_state(r_state);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state         <= StFetch;
            r_cause         <= CauseUndef;
            r_instr_retired <= '0;
        end else begin
            r_state <= w_state_next;
            r_cause <= w_cause_next;
            if (w_retire) begin
                r_instr_retired <= r_instr_retired + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        w_state_next = StFetch;
        w_cause_next = r_cause;
        case (r_state)
            StFetch: w_state_next = StDecode;
            StDecode: begin
                case (Opcode)
                    OpLw, OpSw:              w_state_next = StMemAddr;
                    OpRType:                 w_state_next = (Funct == FnJr) ? StJr : StRExec;
                    OpBeq, OpBne:            w_state_next = StBranch;
                    OpJ:                     w_state_next = StJump;
                    OpAddi, OpAndi, OpOri:   w_state_next = StIExec;
                    default: begin
                        w_state_next = StException;
                        w_cause_next = CauseUndef;
                    end
                endcase
            end
            StMemAddr: w_state_next = (Opcode == OpLw) ? StMemRead : StMemWrite;
            StMemRead: w_state_next = StMemWb;
            StRExec: begin
                // Only the trapping signed forms raise an overflow exception.
                if (Overflow && ((Funct == FnAdd) || (Funct == FnSub))) begin
                    w_state_next = StException;
                    w_cause_next = CauseOverflow;
                end else begin
                    w_state_next = StRWb;
                end
            end
            StIExec: begin
                if (Overflow && (Opcode == OpAddi)) begin
                    w_state_next = StException;
                    w_cause_next = CauseOverflow;
                end else begin
                    w_state_next = StIWb;
                end
            end
            default: w_state_next = StFetch;
        endcase
    end

    always_comb begin
        w_ctrl = '0;
        case (r_state)
            StFetch: begin
                w_ctrl.ir_en     = 1'b1;
                w_ctrl.alu_src_b = AluSrcBFour;
                w_ctrl.alu_op    = AluOpAdd;
                w_ctrl.pc_sel    = PcSelAluOut;
                w_ctrl.pc_load   = 1'b1;
            end
            StDecode: begin
                w_ctrl.alu_src_b = AluSrcBImmShift;
                w_ctrl.alu_op    = AluOpAdd;
            end
            StMemAddr: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = AluSrcBImm;
                w_ctrl.alu_op    = AluOpAdd;
            end
            StMemRead: w_ctrl.iord = 1'b1;
            StMemWb: begin
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.reg_write  = 1'b1;
            end
            StMemWrite: begin
                w_ctrl.iord      = 1'b1;
                w_ctrl.mem_write = 1'b1;
            end
            StRExec: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = AluSrcBReg2;
                w_ctrl.alu_op    = AluOpFunct;
            end
            StRWb: begin
                w_ctrl.reg_dst   = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            StIExec: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = AluSrcBImm;
                w_ctrl.alu_op    = AluOpImm;
            end
            StIWb: w_ctrl.reg_write = 1'b1;
            StBranch: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = AluSrcBReg2;
                w_ctrl.alu_op    = AluOpSub;
                w_ctrl.pc_sel    = PcSelAluRegOut;
                w_ctrl.pc_load   = (Opcode == OpBne) ? ~Zero : Zero;
            end
            StJump: begin
                w_ctrl.pc_sel  = PcSelJump;
                w_ctrl.pc_load = 1'b1;
            end
            StJr: begin
                w_ctrl.pc_sel  = PcSelReg1;
                w_ctrl.pc_load = 1'b1;
            end
            StException: begin
                w_ctrl.epc_en  = 1'b1;
                w_ctrl.pc_sel  = PcSelVector;
                w_ctrl.pc_load = 1'b1;
            end
            default: w_ctrl = '0;
        endcase
        // Reset aborts the current instruction with every control quiet.
        if (RST) begin
            w_ctrl = '0;
        end
    end

    assign PC_LOAD       = w_ctrl.pc_load;
    assign IorD          = w_ctrl.iord;
    assign IR_EN         = w_ctrl.ir_en;
    assign EPC_EN        = w_ctrl.epc_en;
    assign PC_SEL        = w_ctrl.pc_sel;
    assign MemWrite      = w_ctrl.mem_write;
    assign RegWrite      = w_ctrl.reg_write;
    assign RegDst        = w_ctrl.reg_dst;
    assign MemtoReg      = w_ctrl.mem_to_reg;
    assign ALUSrcA       = w_ctrl.alu_src_a;
    assign ALUSrcB       = w_ctrl.alu_src_b;
    assign ALUOp         = w_ctrl.alu_op;
    assign Cause         = r_cause;
    assign INSTR_RETIRED = r_instr_retired;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: per-cycle expected control words are queued by
// the stimulus and popped by a negedge monitor. A 4-bit counter makes the wrap reachable.
module tb_multicycle_control_unit;

    localparam int unsigned CW = 4;

    localparam int P_RESET = 0;
    localparam int P_FETCH = 1;
    localparam int P_DEC   = 2;
    localparam int P_MADDR = 3;
    localparam int P_MRD   = 4;
    localparam int P_MWB   = 5;
    localparam int P_MWR   = 6;
    localparam int P_REX   = 7;
    localparam int P_RWB   = 8;
    localparam int P_IEX   = 9;
    localparam int P_IWB   = 10;
    localparam int P_BR    = 11;
    localparam int P_J     = 12;
    localparam int P_JR    = 13;
    localparam int P_EXC   = 14;

    typedef struct packed {
        logic          pc_load;
        logic          iord;
        logic          ir_en;
        logic          epc_en;
        logic [2:0]    pc_sel;
        logic          mem_write;
        logic          reg_write;
        logic          reg_dst;
        logic          mem_to_reg;
        logic          alu_src_a;
        logic [1:0]    alu_src_b;
        logic [1:0]    alu_op;
        logic          cause;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RST;
    logic [5:0]    Opcode;
    logic [5:0]    Funct;
    logic          Zero;
    logic          Overflow;
    logic          PC_LOAD, IorD, IR_EN, EPC_EN, MemWrite, RegWrite, RegDst, MemtoReg, ALUSrcA;
    logic [2:0]    PC_SEL;
    logic [1:0]    ALUSrcB, ALUOp;
    logic          Cause;
    logic [CW-1:0] INSTR_RETIRED;

    exp_t          exp_q[$];
    string         name_q[$];
    int            n_checks = 0;
    int            n_errors = 0;
    logic [CW-1:0] exp_cnt  = '0;
    logic          exp_cause = 1'b0;

    multicycle_control_unit #(.CNT_WIDTH(CW)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .Opcode       (Opcode),
        .Funct        (Funct),
        .Zero         (Zero),
        .Overflow     (Overflow),
        .PC_LOAD      (PC_LOAD),
        .IorD         (IorD),
        .IR_EN        (IR_EN),
        .EPC_EN       (EPC_EN),
        .PC_SEL       (PC_SEL),
        .MemWrite     (MemWrite),
        .RegWrite     (RegWrite),
        .RegDst       (RegDst),
        .MemtoReg     (MemtoReg),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ALUOp        (ALUOp),
        .Cause        (Cause),
        .INSTR_RETIRED(INSTR_RETIRED)
    );

    always #5 CLK = ~CLK;

    // Control word each state must drive, straight from the state table.
    function automatic exp_t ph(input int p, input logic ld);
        exp_t e;
        e = '0;
        case (p)
            P_FETCH: begin e.ir_en = 1; e.alu_src_b = 2'd1; e.pc_load = 1; end
            P_DEC:   e.alu_src_b = 2'd3;
            P_MADDR: begin e.alu_src_a = 1; e.alu_src_b = 2'd2; end
            P_MRD:   e.iord = 1;
            P_MWB:   begin e.mem_to_reg = 1; e.reg_write = 1; end
            P_MWR:   begin e.iord = 1; e.mem_write = 1; end
            P_REX:   begin e.alu_src_a = 1; e.alu_op = 2'd2; end
            P_RWB:   begin e.reg_dst = 1; e.reg_write = 1; end
            P_IEX:   begin e.alu_src_a = 1; e.alu_src_b = 2'd2; e.alu_op = 2'd3; end
            P_IWB:   e.reg_write = 1;
            P_BR:    begin e.alu_src_a = 1; e.alu_op = 2'd1; e.pc_sel = 3'd1; e.pc_load = ld; end
            P_J:     begin e.pc_sel = 3'd2; e.pc_load = 1; end
            P_JR:    begin e.pc_sel = 3'd3; e.pc_load = 1; end
            P_EXC:   begin e.epc_en = 1; e.pc_sel = 3'd4; e.pc_load = 1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic set_in(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic ov);
        Opcode   = op;
        Funct    = fn;
        Zero     = z;
        Overflow = ov;
    endtask

    task automatic chk(input int p, input logic ld, input string nm);
        exp_t e;
        e       = ph(p, ld);
        e.cause = exp_cause;
        e.cnt   = exp_cnt;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge CLK);
        #1;
    endtask

    task automatic fd(input string nm);
        chk(P_FETCH, 1'b0, {nm, "_fetch"});
        chk(P_DEC, 1'b0, {nm, "_decode"});
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  a;
            string nm;
            e = exp_q.pop_front();
            nm = name_q.pop_front();
            a = '{pc_load: PC_LOAD, iord: IorD, ir_en: IR_EN, epc_en: EPC_EN, pc_sel: PC_SEL,
                  mem_write: MemWrite, reg_write: RegWrite, reg_dst: RegDst, mem_to_reg: MemtoReg,
                  alu_src_a: ALUSrcA, alu_src_b: ALUSrcB, alu_op: ALUOp, cause: Cause,
                  cnt: INSTR_RETIRED};
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL %s: got=%h expected=%h (cnt got %0d exp %0d)",
                         nm, a, e, a.cnt, e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1;
        set_in(6'h23, 6'h00, 1'b0, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        chk(P_RESET, 1'b0, "reset");
        RST = 1'b0;

        set_in(6'h23, 6'h00, 1'b0, 1'b0);
        fd("lw");
        chk(P_MADDR, 1'b0, "lw_addr");
        chk(P_MRD, 1'b0, "lw_read");
        chk(P_MWB, 1'b0, "lw_wb");
        exp_cnt++;

        set_in(6'h2B, 6'h00, 1'b0, 1'b0);
        fd("sw");
        chk(P_MADDR, 1'b0, "sw_addr");
        chk(P_MWR, 1'b0, "sw_write");
        exp_cnt++;

        set_in(6'h04, 6'h00, 1'b1, 1'b0);
        fd("beq_z1");
        chk(P_BR, 1'b1, "beq_z1_branch");
        exp_cnt++;
        set_in(6'h04, 6'h00, 1'b0, 1'b0);
        fd("beq_z0");
        chk(P_BR, 1'b0, "beq_z0_branch");
        exp_cnt++;
        set_in(6'h05, 6'h00, 1'b0, 1'b0);
        fd("bne_z0");
        chk(P_BR, 1'b1, "bne_z0_branch");
        exp_cnt++;
        set_in(6'h05, 6'h00, 1'b1, 1'b0);
        fd("bne_z1");
        chk(P_BR, 1'b0, "bne_z1_branch");
        exp_cnt++;

        set_in(6'h00, 6'h20, 1'b0, 1'b0);
        fd("add");
        chk(P_REX, 1'b0, "add_exec");
        chk(P_RWB, 1'b0, "add_wb");
        exp_cnt++;

        set_in(6'h08, 6'h00, 1'b0, 1'b0);
        fd("addi");
        chk(P_IEX, 1'b0, "addi_exec");
        chk(P_IWB, 1'b0, "addi_wb");
        exp_cnt++;

        // Overflow on non-trapping forms must still write back.
        set_in(6'h0D, 6'h00, 1'b0, 1'b1);
        fd("ori_ovf");
        chk(P_IEX, 1'b0, "ori_ovf_exec");
        chk(P_IWB, 1'b0, "ori_ovf_wb");
        exp_cnt++;
        set_in(6'h00, 6'h21, 1'b0, 1'b1);
        fd("addu_ovf");
        chk(P_REX, 1'b0, "addu_ovf_exec");
        chk(P_RWB, 1'b0, "addu_ovf_wb");
        exp_cnt++;

        set_in(6'h00, 6'h20, 1'b0, 1'b1);
        fd("add_ovf");
        chk(P_REX, 1'b0, "add_ovf_exec");
        exp_cause = 1'b1;
        chk(P_EXC, 1'b0, "add_ovf_exc");

        set_in(6'h3F, 6'h00, 1'b0, 1'b0);
        fd("undef");
        exp_cause = 1'b0;
        chk(P_EXC, 1'b0, "undef_exc");

        set_in(6'h00, 6'h08, 1'b0, 1'b0);
        fd("jr");
        chk(P_JR, 1'b0, "jr_jr");
        exp_cnt++;

        set_in(6'h02, 6'h00, 1'b0, 1'b0);
        fd("j");
        chk(P_J, 1'b0, "j_jump");
        exp_cnt++;

        set_in(6'h08, 6'h00, 1'b0, 1'b1);
        fd("addi_ovf");
        chk(P_IEX, 1'b0, "addi_ovf_exec");
        exp_cause = 1'b1;
        chk(P_EXC, 1'b0, "addi_ovf_exc");

        set_in(6'h2B, 6'h00, 1'b0, 1'b0);
        fd("sw_rst");
        chk(P_MADDR, 1'b0, "sw_rst_addr");
        RST = 1'b1;
        chk(P_RESET, 1'b0, "sw_rst_write");
        RST = 1'b0;
        exp_cnt   = '0;
        exp_cause = 1'b0;

        // Sixteen jumps walk the 4-bit counter through all-ones and back to zero.
        for (int i = 0; i < 16; i++) begin
            set_in(6'h02, 6'h00, 1'b0, 1'b0);
            fd("wrap_j");
            chk(P_J, 1'b0, "wrap_j_jump");
            exp_cnt++;
        end
        chk(P_FETCH, 1'b0, "wrap_zero_fetch");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge CLK);
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
